m_timer_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 15 +
 rtl/m_btn_debounce.sv | 50 +++++
 rtl/m_timer_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_m_timer_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the kitchen-timer control block: state encoding and
// default timing constants.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam int TICK_DIV_DEF  = 50000000;
  localparam int DB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/m_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on the rising edge of the accepted level.
module m_btn_debounce
  import timer_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          level_r;
  logic          press_r;

  // Synchronize the raw input, count consecutive mismatches, flip on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= '0;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CW'(DB_CYCLES - 1)) begin
        cnt_r   <= '0;
        level_r <= sync2_r;
        press_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/m_timer_ctrl.sv
// Kitchen-timer control FSM: debounced buttons, 1 s prescaler, datapath strobes
// and alarm buzzer. Optional button auto-repeat under TIMER_AUTOREPEAT_EN.
module m_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int ALARM_SEC  = 10,
  parameter int BEEP_DIV   = 25000,
  parameter int REPEAT_CYC = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_clr,
  input  logic       dp_zero,
  output logic       dp_tick,
  output logic       dp_min_inc,
  output logic       dp_sec_inc,
  output logic       dp_clear,
  output logic       dp_run,
  output logic       buzzer,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam int BW = $clog2(BEEP_DIV + 1);

  logic lvl_start, lvl_min, lvl_sec, lvl_clr;
  logic p_start, p_min, p_sec, p_clr;
  logic act_clr_s, act_start_s, act_min_s, act_sec_s, any_press_s;
  logic rpt_min_s, rpt_sec_s;
  logic unused_s;

  state_t        state_r, state_nx;
  logic [PW-1:0] presc_r;
  logic [AW-1:0] alarm_r;
  logic [BW-1:0] beep_r;
  logic          buzzer_r;
  logic          tick_r, min_r, sec_r, clr_r, run_r;
  logic          tick_s, min_s, sec_s, clr_s, presc_clr_s, wrap_s;

  m_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (.clk(clk), .rst_n(rst_n), .raw(btn_start), .level(lvl_start), .press(p_start));
  m_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_min   (.clk(clk), .rst_n(rst_n), .raw(btn_min),   .level(lvl_min),   .press(p_min));
  m_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sec   (.clk(clk), .rst_n(rst_n), .raw(btn_sec),   .level(lvl_sec),   .press(p_sec));
  m_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr   (.clk(clk), .rst_n(rst_n), .raw(btn_clr),   .level(lvl_clr),   .press(p_clr));

  // Only the highest-priority press of a cycle acts: clr > start > min > sec
  assign act_clr_s   = p_clr;
  assign act_start_s = p_start & ~p_clr;
  assign act_min_s   = p_min & ~p_clr & ~p_start;
  assign act_sec_s   = p_sec & ~p_clr & ~p_start & ~p_min;
  assign any_press_s = p_clr | p_start | p_min | p_sec;
  assign wrap_s      = (presc_r == PW'(TICK_DIV - 1));

  assign unused_s = ^{lvl_start, lvl_clr, lvl_min, lvl_sec, (REPEAT_CYC > 0)};

`ifdef TIMER_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC + 1);
  logic [RW-1:0] rpt_cnt_r;
  logic          rpt_on_r;
  logic          rpt_sel_sec_r;
  logic          held_s, rpt_due_s;

  assign held_s    = rpt_sel_sec_r ? lvl_sec : lvl_min;
  assign rpt_due_s = rpt_on_r & held_s & (state_r == ST_SET) & ~any_press_s &
                     (rpt_cnt_r == RW'(REPEAT_CYC - 1));
  assign rpt_min_s = rpt_due_s & ~rpt_sel_sec_r;
  assign rpt_sec_s = rpt_due_s & rpt_sel_sec_r;

  // Repeat timer: armed by a min/sec press in SET, dropped on release or another press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_r     <= '0;
      rpt_on_r      <= 1'b0;
      rpt_sel_sec_r <= 1'b0;
    end else if ((state_r != ST_SET) || act_clr_s || act_start_s) begin
      rpt_cnt_r <= '0;
      rpt_on_r  <= 1'b0;
    end else if (act_min_s || act_sec_s) begin
      rpt_cnt_r     <= '0;
      rpt_on_r      <= 1'b1;
      rpt_sel_sec_r <= act_sec_s;
    end else if (!held_s) begin
      rpt_cnt_r <= '0;
      rpt_on_r  <= 1'b0;
    end else if (rpt_cnt_r == RW'(REPEAT_CYC - 1)) begin
      rpt_cnt_r <= '0;
    end else begin
      rpt_cnt_r <= rpt_cnt_r + RW'(1);
    end
  end
`else
  assign rpt_min_s = 1'b0;
  assign rpt_sec_s = 1'b0;
`endif

  // Next-state and strobe decode
  always_comb begin
    state_nx    = state_r;
    tick_s      = 1'b0;
    min_s       = 1'b0;
    sec_s       = 1'b0;
    clr_s       = 1'b0;
    presc_clr_s = 1'b0;
    case (state_r)
      ST_SET: begin
        if (act_clr_s) begin
          clr_s = 1'b1;
        end else if (act_start_s) begin
          if (!dp_zero) begin
            state_nx    = ST_RUN;
            presc_clr_s = 1'b1;
          end else begin
            state_nx = ST_SET;
          end
        end else if (act_min_s || rpt_min_s) begin
          min_s = 1'b1;
        end else if (act_sec_s || rpt_sec_s) begin
          sec_s = 1'b1;
        end else begin
          state_nx = ST_SET;
        end
      end
      ST_RUN: begin
        if (act_clr_s) begin
          state_nx = ST_SET;
          clr_s    = 1'b1;
        end else if (dp_zero) begin
          state_nx    = ST_ALARM;
          presc_clr_s = 1'b1;
        end else if (act_start_s) begin
          state_nx = ST_PAUSE;
          tick_s   = wrap_s;
        end else begin
          tick_s = wrap_s;
        end
      end
      ST_PAUSE: begin
        if (act_clr_s) begin
          state_nx = ST_SET;
          clr_s    = 1'b1;
        end else if (act_start_s) begin
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (any_press_s) begin
          state_nx = ST_SET;
        end else if (wrap_s && (alarm_r == AW'(ALARM_SEC - 1))) begin
          state_nx = ST_SET;
        end else begin
          state_nx = ST_ALARM;
        end
      end
      default: state_nx = ST_SET;
    endcase
  end

  // State, prescaler, alarm seconds and buzzer divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_SET;
      presc_r  <= '0;
      alarm_r  <= '0;
      beep_r   <= '0;
      buzzer_r <= 1'b0;
    end else begin
      state_r <= state_nx;
      // PAUSE and SET hold the prescaler so a partial second survives a pause
      if (presc_clr_s) begin
        presc_r <= '0;
      end else if ((state_r == ST_RUN) || (state_r == ST_ALARM)) begin
        presc_r <= wrap_s ? '0 : presc_r + PW'(1);
      end else begin
        presc_r <= presc_r;
      end
      if (state_r != ST_ALARM) begin
        alarm_r <= '0;
      end else if (wrap_s) begin
        alarm_r <= alarm_r + AW'(1);
      end else begin
        alarm_r <= alarm_r;
      end
      if ((state_r != ST_ALARM) || (state_nx != ST_ALARM)) begin
        beep_r   <= '0;
        buzzer_r <= 1'b0;
      end else if (beep_r == BW'(BEEP_DIV - 1)) begin
        beep_r   <= '0;
        buzzer_r <= ~buzzer_r;
      end else begin
        beep_r <= beep_r + BW'(1);
      end
    end
  end

  // Registered datapath strobes and mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_r <= 1'b0;
      min_r  <= 1'b0;
      sec_r  <= 1'b0;
      clr_r  <= 1'b0;
      run_r  <= 1'b0;
    end else begin
      tick_r <= tick_s;
      min_r  <= min_s;
      sec_r  <= sec_s;
      clr_r  <= clr_s;
      run_r  <= (state_nx == ST_RUN);
    end
  end

  assign dp_tick    = tick_r;
  assign dp_min_inc = min_r;
  assign dp_sec_inc = sec_r;
  assign dp_clear   = clr_r;
  assign dp_run     = run_r;
  assign buzzer     = buzzer_r;
  assign state      = state_r;

endmodule

// File: tb/tb_m_timer_ctrl.sv
// Self-checking bench for m_timer_ctrl with a behavioural min:sec datapath and a
// queue of expected strobes (kind and cycle) compared as strobes appear.
module tb_m_timer_ctrl;

  localparam int TICK_DIV   = 10;
  localparam int DB_CYCLES  = 4;
  localparam int ALARM_SEC  = 3;
  localparam int BEEP_DIV   = 2;
  localparam int REPEAT_CYC = 8;

  localparam int K_TICK = 0, K_MIN = 1, K_SEC = 2, K_CLR = 3;
  localparam int B_START = 0, B_MIN = 1, B_SEC = 2, B_CLR = 3;
  localparam int S_SET = 0, S_RUN = 1, S_PAUSE = 2, S_ALARM = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_start = 1'b0, btn_min = 1'b0, btn_sec = 1'b0, btn_clr = 1'b0;
  logic dp_zero;
  logic dp_tick, dp_min_inc, dp_sec_inc, dp_clear, dp_run, buzzer;
  logic [1:0] state;

  m_timer_ctrl #(
    .TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES), .ALARM_SEC(ALARM_SEC),
    .BEEP_DIV(BEEP_DIV), .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_min(btn_min), .btn_sec(btn_sec), .btn_clr(btn_clr),
    .dp_zero(dp_zero),
    .dp_tick(dp_tick), .dp_min_inc(dp_min_inc), .dp_sec_inc(dp_sec_inc),
    .dp_clear(dp_clear), .dp_run(dp_run), .buzzer(buzzer), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath
  int mins = 0;
  int secs = 0;
  always @(posedge clk) begin
    if (dp_clear) begin
      mins <= 0; secs <= 0;
    end else if (dp_min_inc) begin
      mins <= (mins + 1) % 100;
    end else if (dp_sec_inc) begin
      secs <= (secs + 1) % 60;
    end else if (dp_tick) begin
      if (secs > 0) secs <= secs - 1;
      else if (mins > 0) begin mins <= mins - 1; secs <= 59; end
    end
  end
  assign dp_zero = (mins == 0) && (secs == 0);

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct { int at; int kind; } ev_t;
  ev_t sb[$];

  task automatic expect_strobe(input int kind, input int at);
    ev_t e;
    e.at = at; e.kind = kind;
    sb.push_back(e);
  endtask

  // Strobe monitor: every strobe must match the next expected entry
  always @(negedge clk) begin
    int n, kind;
    ev_t e;
    if (rst_n) begin
      n = int'(dp_tick) + int'(dp_min_inc) + int'(dp_sec_inc) + int'(dp_clear);
      if (n > 0) begin
        check_val("strobe_onehot", n, 1);
        kind = dp_tick ? K_TICK : dp_min_inc ? K_MIN : dp_sec_inc ? K_SEC : K_CLR;
        if (sb.size() == 0) begin
          check_val("unexpected_strobe_kind", kind, -1);
        end else begin
          e = sb.pop_front();
          check_val("strobe_kind", kind, e.kind);
          check_val("strobe_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto_cyc(input int t);
    if (cyc > t) check_val("schedule", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic btn_set(input int b, input logic v);
    case (b)
      B_START: btn_start = v;
      B_MIN:   btn_min   = v;
      B_SEC:   btn_sec   = v;
      default: btn_clr   = v;
    endcase
  endtask

  // Clean press: 6 cycles high, 8 low; strobe (if any) 7 cycles after the raw edge
  task automatic tap(input int b, input int kind);
    if (kind >= 0) expect_strobe(kind, cyc + 7);
    btn_set(b, 1'b1);
    step(6);
    btn_set(b, 1'b0);
    step(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, e, a, r;
    step(3);
    check_val("rst_state", int'(state), S_SET);
    check_val("rst_run", int'(dp_run), 0);
    check_val("rst_buzzer", int'(buzzer), 0);
    check_val("rst_strobes", int'({dp_tick, dp_min_inc, dp_sec_inc, dp_clear}), 0);
    rst_n = 1'b1;
    step(2);

    // 1: bounce then hold -> one min strobe 7 cycles after the last rising edge
    btn_min = 1'b1; step(1); btn_min = 1'b0; step(1);
    btn_min = 1'b1; step(1); btn_min = 1'b0; step(1);
    btn_min = 1'b1;
    expect_strobe(K_MIN, cyc + 7);
    step(10);
    btn_min = 1'b0;
    step(10);
    check_val("t1_mins", mins, 1);
    check_val("t1_sb_empty", sb.size(), 0);
    tap(B_CLR, K_CLR);
    check_val("t1_cleared", int'(dp_zero), 1);

    // 2: 00:02, run, two ticks, then ALARM
    tap(B_SEC, K_SEC);
    tap(B_SEC, K_SEC);
    check_val("t2_secs", secs, 2);
    e = cyc + 7;
    expect_strobe(K_TICK, e + 10);
    expect_strobe(K_TICK, e + 20);
    tap(B_START, -1);
    check_val("t2_state_run", int'(state), S_RUN);
    check_val("t2_dp_run", int'(dp_run), 1);
    goto_cyc(e + 21);
    check_val("t2_zero", int'(dp_zero), 1);
    check_val("t2_still_run", int'(state), S_RUN);
    goto_cyc(e + 22);
    check_val("t2_alarm", int'(state), S_ALARM);
    check_val("t2_run_off", int'(dp_run), 0);

    // 3: buzzer pattern over the 30-cycle alarm, then back to SET
    a = e + 22;
    for (int i = 0; i < 30; i++) begin
      goto_cyc(a + i);
      check_val("t3_buzzer", int'(buzzer), (i / 2) % 2);
      check_val("t3_alarm_state", int'(state), S_ALARM);
    end
    goto_cyc(a + 30);
    check_val("t3_set", int'(state), S_SET);
    check_val("t3_buzzer_off", int'(buzzer), 0);
    check_val("t3_sb_empty", sb.size(), 0);

    tap(B_SEC, K_SEC);
    e = cyc + 7;
    expect_strobe(K_TICK, e + 10);
    tap(B_START, -1);
    goto_cyc(e + 12);
    check_val("t3b_alarm", int'(state), S_ALARM);
    d = cyc;
    btn_set(B_SEC, 1'b1);
    goto_cyc(d + 6);
    check_val("t3b_before", int'(state), S_ALARM);
    btn_set(B_SEC, 1'b0);
    goto_cyc(d + 7);
    check_val("t3b_set", int'(state), S_SET);
    check_val("t3b_buzzer", int'(buzzer), 0);
    step(8);
    check_val("t3b_no_inc", int'(dp_zero), 1);

    // 4: pause at prescaler 6, resume -> tick 3 cycles after re-entry
    for (int i = 0; i < 5; i++) tap(B_SEC, K_SEC);
    e = cyc + 7;
    expect_strobe(K_TICK, e + 10);
    tap(B_START, -1);
    goto_cyc(e + 10);
    btn_set(B_START, 1'b1);
    goto_cyc(e + 16);
    btn_set(B_START, 1'b0);
    goto_cyc(e + 17);
    check_val("t4_pause", int'(state), S_PAUSE);
    check_val("t4_pause_run", int'(dp_run), 0);
    d = e + 67;
    goto_cyc(d);
    check_val("t4_pause_held", int'(state), S_PAUSE);
    check_val("t4_secs_held", secs, 4);
    r = d + 7;
    expect_strobe(K_TICK, r + 3);
    btn_set(B_START, 1'b1);
    goto_cyc(d + 6);
    btn_set(B_START, 1'b0);
    goto_cyc(r);
    check_val("t4_resume", int'(state), S_RUN);

    // 5: clr+start+min together in RUN -> single clear, SET
    goto_cyc(r + 5);
    d = cyc;
    expect_strobe(K_CLR, d + 7);
    btn_clr = 1'b1; btn_start = 1'b1; btn_min = 1'b1;
    goto_cyc(d + 6);
    check_val("t5_before", int'(state), S_RUN);
    btn_clr = 1'b0; btn_start = 1'b0; btn_min = 1'b0;
    goto_cyc(d + 7);
    check_val("t5_set", int'(state), S_SET);
    step(10);
    check_val("t5_zero", int'(dp_zero), 1);
    check_val("t5_mins", mins, 0);
    d = cyc;
    btn_set(B_START, 1'b1);
    goto_cyc(d + 6);
    btn_set(B_START, 1'b0);
    goto_cyc(d + 9);
    check_val("t5_start_zero", int'(state), S_SET);
    check_val("t5_start_zero_run", int'(dp_run), 0);
    step(8);
    check_val("t5_sb_empty", sb.size(), 0);

    // 6: asynchronous reset mid-RUN at prescaler 5
    tap(B_SEC, K_SEC);
    tap(B_SEC, K_SEC);
    e = cyc + 7;
    expect_strobe(K_TICK, e + 10);
    tap(B_START, -1);
    goto_cyc(e + 15);
    check_val("t6_running", int'(dp_run), 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_state", int'(state), S_SET);
    check_val("t6_rst_run", int'(dp_run), 0);
    check_val("t6_rst_buzzer", int'(buzzer), 0);
    check_val("t6_rst_strobes", int'({dp_tick, dp_min_inc, dp_sec_inc, dp_clear}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check_val("t6_after_state", int'(state), S_SET);
    check_val("t6_dp_kept", secs, 1);

`ifdef TIMER_AUTOREPEAT_EN
    d = cyc;
    expect_strobe(K_SEC, d + 7);
    expect_strobe(K_SEC, d + 15);
    expect_strobe(K_SEC, d + 23);
    expect_strobe(K_SEC, d + 31);
    btn_set(B_SEC, 1'b1);
    goto_cyc(d + 30);
    btn_set(B_SEC, 1'b0);
    goto_cyc(d + 50);
    check_val("t6_repeat_secs", secs, 5);
`endif

    step(5);
    check_val("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
